// File: rtl/cal_pkg.sv
// Shared types, encodings and date rules for the calendar set controller.
package cal_pkg;

  typedef enum logic [3:0] {
    JAN, FEB, MAR, APR, MAY, JUN, JUL, AUG, SEP, OCT, NOV, DEC
  } month_e;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_COMMIT = 2'b01;
  localparam logic [1:0] OP_ABORT  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [2:0] FLD_SEC   = 3'd0;
  localparam logic [2:0] FLD_MIN   = 3'd1;
  localparam logic [2:0] FLD_HRS   = 3'd2;
  localparam logic [2:0] FLD_DAY   = 3'd3;
  localparam logic [2:0] FLD_MONTH = 3'd4;
  localparam logic [2:0] FLD_LEAP  = 3'd5;

  localparam int unsigned SEC_LIMIT   = 60;
  localparam int unsigned MIN_LIMIT   = 60;
  localparam int unsigned HRS_LIMIT   = 24;
  localparam int unsigned MONTH_LIMIT = 12;

  typedef enum logic [1:0] {ST_RUN, ST_EDIT, ST_CHECK, ST_LOAD} state_e;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hrs;
    logic [4:0] day;
    logic [3:0] month;
    logic       leap;
  } cal_time_t;

  localparam cal_time_t CAL_TIME_RST = '{sec: 6'd0, min: 6'd0, hrs: 5'd0,
                                         day: 5'd1, month: 4'd0, leap: 1'b0};

  // Month codes 12..15 yield 0 so any day fails validation.
  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
    case (month_e'(month))
      FEB:                               return leap ? 5'd29 : 5'd28;
      APR, JUN, SEP, NOV:                return 5'd30;
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: return 5'd31;
      default:                           return 5'd0;
    endcase
  endfunction

  function automatic logic write_legal(input logic [2:0] field, input logic [5:0] data);
    case (field)
      FLD_SEC:   return data < 6'(SEC_LIMIT);
      FLD_MIN:   return data < 6'(MIN_LIMIT);
      FLD_HRS:   return data < 6'(HRS_LIMIT);
      FLD_DAY:   return (data != 6'd0) && !data[5];
      FLD_MONTH: return data < 6'(MONTH_LIMIT);
      FLD_LEAP:  return data[5:1] == 5'd0;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cal_set_ctrl_if.sv
// Host command port: valid/ready handshake carrying op, field and data.
interface cal_set_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_field;
  logic [5:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_field, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_field, cmd_data, output cmd_ready);
endinterface

// File: rtl/cal_prescaler.sv
// Divides clk down to a one-cycle count tick; count is held at zero while disabled.
module cal_prescaler #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tick    = en && (count_q == TC);
    count_d = (!en || tick) ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/cal_set_ctrl.sv
// Calendar set controller: host edits a shadow date, COMMIT validates it and
// issues a one-cycle load to the counter; counting pauses while editing.
module cal_set_ctrl
  import cal_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  cal_set_ctrl_if.slave cmd,
  input  logic [5:0] cur_sec,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hrs,
  input  logic [4:0] cur_day,
  input  logic [3:0] cur_month,
  input  logic       cur_leap,
  output logic       tick,
  output logic       load,
  output logic [5:0] ld_sec,
  output logic [5:0] ld_min,
  output logic [4:0] ld_hrs,
  output logic [4:0] ld_day,
  output logic [3:0] ld_month,
  output logic       ld_leap,
  output logic       editing,
  output logic       err
);

  state_e    state_q, state_d;
  cal_time_t shadow_q, shadow_d;
  cal_time_t ld_q, ld_d;
  logic      load_q, load_d;
  logic      err_q, err_d;
  logic      editing_q, editing_d;

  cal_time_t cur_time;
  logic      ready, accept, wr_legal, wr_take, day_ok, presc_en;

  function automatic cal_time_t put_field(input cal_time_t t, input logic [2:0] field,
                                          input logic [5:0] data);
    cal_time_t r;
    r = t;
    case (field)
      FLD_SEC:   r.sec   = data;
      FLD_MIN:   r.min   = data;
      FLD_HRS:   r.hrs   = data[4:0];
      FLD_DAY:   r.day   = data[4:0];
      FLD_MONTH: r.month = data[3:0];
      FLD_LEAP:  r.leap  = data[0];
      default:   ;
    endcase
    return r;
  endfunction

  assign cur_time = '{sec: cur_sec, min: cur_min, hrs: cur_hrs,
                      day: cur_day, month: cur_month, leap: cur_leap};

  assign ready         = (state_q == ST_RUN) || (state_q == ST_EDIT);
  assign cmd.cmd_ready = ready;
  assign accept        = cmd.cmd_valid && ready;
  assign wr_legal      = write_legal(cmd.cmd_field, cmd.cmd_data);
  assign wr_take       = accept && (cmd.cmd_op == OP_WRITE) && wr_legal;
  assign day_ok        = (shadow_q.day != 5'd0) &&
                         (shadow_q.day <= days_in_month(shadow_q.month, shadow_q.leap));

  // An accepted legal write in RUN opens an edit, so that cycle must not tick.
  assign presc_en = (state_q == ST_RUN) && !wr_take;

  cal_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ld_d     = ld_q;
    load_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept && (cmd.cmd_op == OP_WRITE)) begin
          if (wr_legal) begin
            shadow_d = put_field(cur_time, cmd.cmd_field, cmd.cmd_data);
            state_d  = ST_EDIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EDIT: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_WRITE: begin
              if (wr_legal) shadow_d = put_field(shadow_q, cmd.cmd_field, cmd.cmd_data);
              else          err_d    = 1'b1;
            end
            OP_COMMIT: state_d = ST_CHECK;
            OP_ABORT:  state_d = ST_RUN;
            default:   ;
          endcase
        end
      end
      ST_CHECK: begin
        if (day_ok) begin
          state_d = ST_LOAD;
          load_d  = 1'b1;
          ld_d    = shadow_q;
        end else begin
          state_d = ST_EDIT;
          err_d   = 1'b1;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    editing_d = (state_d == ST_EDIT) || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      shadow_q  <= CAL_TIME_RST;
      ld_q      <= CAL_TIME_RST;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      editing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      ld_q      <= ld_d;
      load_q    <= load_d;
      err_q     <= err_d;
      editing_q <= editing_d;
    end
  end

  assign load     = load_q;
  assign err      = err_q;
  assign editing  = editing_q;
  assign ld_sec   = ld_q.sec;
  assign ld_min   = ld_q.min;
  assign ld_hrs   = ld_q.hrs;
  assign ld_day   = ld_q.day;
  assign ld_month = ld_q.month;
  assign ld_leap  = ld_q.leap;

endmodule

// File: tb/tb_cal_set_ctrl.sv
// Self-checking bench for cal_set_ctrl: date-rule model checked every cycle plus directed literals.
module tb_cal_set_ctrl;

  localparam int unsigned CLK_DIV = 4;
  localparam logic [1:0] OPW = 2'b00, OPC = 2'b01, OPA = 2'b10, OPR = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] cur_sec, cur_min;
  logic [4:0] cur_hrs, cur_day;
  logic [3:0] cur_month;
  logic       cur_leap;
  logic       tick, load, editing, err;
  logic [5:0] ld_sec, ld_min;
  logic [4:0] ld_hrs, ld_day;
  logic [3:0] ld_month;
  logic       ld_leap;

  cal_set_ctrl_if cmd_bus();

  cal_set_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_bus),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hrs(cur_hrs), .cur_day(cur_day),
    .cur_month(cur_month), .cur_leap(cur_leap),
    .tick(tick), .load(load),
    .ld_sec(ld_sec), .ld_min(ld_min), .ld_hrs(ld_hrs), .ld_day(ld_day),
    .ld_month(ld_month), .ld_leap(ld_leap),
    .editing(editing), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: date rules, no RTL structure ----------------
  function automatic bit wr_ok(input int f, input int d);
    case (f)
      0, 1:    return d < 60;
      2:       return d < 24;
      3:       return d >= 1 && d <= 31;
      4:       return d < 12;
      5:       return d <= 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int mdays(input int m, input int leap);
    int t[12];
    t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 0 || m > 11) return 0;
    if (m == 1 && leap != 0) return 29;
    return t[m];
  endfunction

  bit m_open = 0;     // an edit session is open (includes the validation cycle)
  bit m_chk  = 0;     // commit being validated this cycle
  bit m_ldph = 0;     // load strobe cycle
  bit m_err  = 0;
  int m_cnt  = 0;     // cycles of counting since last resume, mod CLK_DIV
  int sh[6]   = '{0, 0, 0, 1, 0, 0};
  int m_ld[6] = '{0, 0, 0, 1, 0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_open = 0; m_chk = 0; m_ldph = 0; m_err = 0; m_cnt = 0;
      m_ld = '{0, 0, 0, 1, 0, 0};
    end else begin
      bit acc, lw;
      int f, d;
      f   = int'(cmd_bus.cmd_field);
      d   = int'(cmd_bus.cmd_data);
      acc = cmd_bus.cmd_valid && !m_chk && !m_ldph;
      lw  = acc && cmd_bus.cmd_op == OPW && wr_ok(f, d);
      m_err = 0;
      if (m_ldph) begin
        m_ldph = 0;
        m_cnt  = 0;
      end else if (m_chk) begin
        m_chk = 0;
        if (sh[3] >= 1 && sh[3] <= mdays(sh[4], sh[5])) begin
          m_ldph = 1;
          m_open = 0;
          m_ld   = sh;
        end else begin
          m_err = 1;
        end
      end else begin
        if (!m_open) m_cnt = lw ? 0 : (m_cnt + 1) % int'(CLK_DIV);
        if (acc && cmd_bus.cmd_op == OPW) begin
          if (lw) begin
            if (!m_open) begin
              sh = '{int'(cur_sec), int'(cur_min), int'(cur_hrs),
                     int'(cur_day), int'(cur_month), int'(cur_leap)};
              m_open = 1;
            end
            sh[f] = d;
          end else begin
            m_err = 1;
          end
        end else if (acc && m_open && cmd_bus.cmd_op == OPC) begin
          m_chk = 1;
        end else if (acc && m_open && cmd_bus.cmd_op == OPA) begin
          m_open = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit er, et, wv;
    er = !m_chk && !m_ldph;
    wv = cmd_bus.cmd_valid && cmd_bus.cmd_op == OPW &&
         wr_ok(int'(cmd_bus.cmd_field), int'(cmd_bus.cmd_data));
    et = !m_open && er && (m_cnt == int'(CLK_DIV) - 1) && !wv;
    chk("cmp_tick", tick, et);
    chk("cmp_ready", cmd_bus.cmd_ready, er);
    chk("cmp_load", load, m_ldph);
    chk("cmp_err", err, m_err);
    chk("cmp_editing", editing, m_open);
    chk("cmp_ld_sec", ld_sec, m_ld[0]);
    chk("cmp_ld_min", ld_min, m_ld[1]);
    chk("cmp_ld_hrs", ld_hrs, m_ld[2]);
    chk("cmp_ld_day", ld_day, m_ld[3]);
    chk("cmp_ld_month", ld_month, m_ld[4]);
    chk("cmp_ld_leap", ld_leap, m_ld[5]);
  end

  // ---------------- stimulus helpers (called at posedge + 2) ----------------
  task automatic align();
    @(posedge clk);
    #2;
  endtask

  // Returns the cycle in which the handshake completed.
  task automatic send(input logic [1:0] op, input logic [2:0] f, input logic [5:0] d,
                      output int acc_cyc);
    bit done;
    done = 0;
    acc_cyc = -1;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_field = f;
    cmd_bus.cmd_data  = d;
    for (int n = 0; n < 16 && !done; n++) begin
      @(negedge clk);
      if (cmd_bus.cmd_ready) begin
        done = 1;
        acc_cyc = cyc;
      end
      align();
    end
    chk("send_accepted", done, 1);
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_for(input bit want_tick, input int budget, output int at);
    bit seen;
    seen = 0;
    at = -1;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (want_tick ? tick : load) begin
        seen = 1;
        at = cyc;
      end
    end
    chk(want_tick ? "wait_tick" : "wait_load", seen, 1);
  endtask

  task automatic set_cur(input int s, input int mi, input int h, input int dy,
                         input int mo, input int lp);
    cur_sec = 6'(s); cur_min = 6'(mi); cur_hrs = 5'(h);
    cur_day = 5'(dy); cur_month = 4'(mo); cur_leap = 1'(lp);
  endtask

  function automatic int pick_data(input int f);
    if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, 63));
    case (f)
      0, 1:    return int'($urandom_range(0, 59));
      2:       return int'($urandom_range(0, 23));
      3:       return int'($urandom_range(1, 31));
      4:       return int'($urandom_range(0, 11));
      default: return int'($urandom_range(0, 1));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b, t;
    int hits[$];
    rst = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'b00;
    cmd_bus.cmd_field = 3'd0;
    cmd_bus.cmd_data  = 6'd0;
    set_cur(20, 10, 3, 5, 4, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // idle counting after reset
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (tick) hits.push_back(i);
    end
    chk("idle_tick_count", hits.size(), 3);
    if (hits.size() == 3) begin
      chk("idle_tick_1", hits[0], 4);
      chk("idle_tick_2", hits[1], 8);
      chk("idle_tick_3", hits[2], 12);
    end
    chk("idle_load", load, 0);
    chk("idle_ld_day", ld_day, 1);
    align();

    // edit and load
    send(OPW, 3'd2, 6'd22, a);
    send(OPW, 3'd1, 6'd45, a);
    send(OPC, 3'd0, 6'd0, a);
    wait_for(0, 8, t);
    chk("commit_latency", t - a, 2);
    chk("load_hrs", ld_hrs, 22);
    chk("load_min", ld_min, 45);
    chk("load_sec", ld_sec, 20);
    chk("load_day", ld_day, 5);
    chk("load_month", ld_month, 4);
    wait_for(1, 8, b);
    chk("tick_after_load", b - t, 4);
    align();

    // range errors
    send(OPW, 3'd0, 6'd60, a);
    @(negedge clk); chk("err_sec60", err, 1); chk("sec60_stays_run", editing, 0);
    align();
    send(OPW, 3'd7, 6'd3, a);
    @(negedge clk); chk("err_field7", err, 1);
    align();
    send(OPW, 3'd4, 6'd12, a);
    @(negedge clk); chk("err_month12", err, 1);
    align();

    // February validation
    send(OPW, 3'd4, 6'd1, a);
    send(OPW, 3'd3, 6'd29, a);
    send(OPW, 3'd5, 6'd0, a);
    send(OPW, 3'd0, 6'd60, a);
    @(negedge clk); chk("err_edit_sec60", err, 1); chk("edit_kept", editing, 1);
    align();
    send(OPC, 3'd0, 6'd0, a);
    @(negedge clk); chk("check_editing", editing, 1); chk("check_ready", cmd_bus.cmd_ready, 0);
    @(negedge clk); chk("feb29_err", err, 1); chk("feb29_noload", load, 0);
    chk("feb29_back_edit", editing, 1);
    align();
    send(OPW, 3'd5, 6'd1, a);
    send(OPC, 3'd0, 6'd0, a);
    wait_for(0, 8, t);
    chk("leap_latency", t - a, 2);
    chk("leap_day", ld_day, 29);
    chk("leap_month", ld_month, 1);
    chk("leap_flag", ld_leap, 1);
    chk("leap_sec_kept", ld_sec, 20);
    align();

    // April 31 rejected, then abort
    send(OPW, 3'd4, 6'd3, a);
    send(OPW, 3'd3, 6'd31, a);
    send(OPC, 3'd0, 6'd0, a);
    @(negedge clk);
    @(negedge clk); chk("apr31_err", err, 1);
    align();
    send(OPA, 3'd0, 6'd0, a);
    wait_for(1, 8, t);
    chk("abort_tick", t - a, 4);
    chk("abort_no_load", ld_month, 1);
    chk("abort_editing", editing, 0);
    align();

    // no-op commit in RUN
    send(OPC, 3'd0, 6'd0, a);
    @(negedge clk);
    chk("run_commit_ready", cmd_bus.cmd_ready, 1);
    chk("run_commit_editing", editing, 0);
    chk("run_commit_err", err, 0);
    align();

    // backpressure across CHECK/LOAD
    send(OPW, 3'd2, 6'd7, a);
    send(OPC, 3'd0, 6'd0, a);
    send(OPW, 3'd0, 6'd30, b);
    chk("backpressure", b - a, 3);
    chk("bp_loaded_hrs", ld_hrs, 7);
    send(OPA, 3'd0, 6'd0, a);

    // reset during CHECK
    send(OPW, 3'd2, 6'd9, a);
    send(OPC, 3'd0, 6'd0, a);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_load", load, 0);
    chk("rst_editing", editing, 0);
    chk("rst_ld_day", ld_day, 1);
    chk("rst_ld_hrs", ld_hrs, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cmd_bus.cmd_ready, 1);
    align();
    rst = 1'b0;
    repeat (3) align();

    // randomized traffic
    for (int it = 0; it < 1500; it++) begin
      int r, o, f;
      logic [1:0] op;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst = 1'b1;
        align();
        rst = 1'b0;
      end else if (r < 18) begin
        set_cur(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                int'($urandom_range(0, 31)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 28)),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 11)),
                int'($urandom_range(0, 1)));
        align();
      end else if (r < 28) begin
        align();
      end else begin
        o = int'($urandom_range(0, 9));
        op = (o < 6) ? OPW : (o < 8) ? OPC : (o == 8) ? OPA : OPR;
        f = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
        send(op, 3'(f), 6'(pick_data(f)), a);
      end
    end
    repeat (4) align();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
